// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
// Free-running VGA raster timing generator. It produces horizontal and
// vertical counters, sync and blanking flags, and line and frame start
// strobes, plus a 16-bit frame counter. Every output is a flop. All flags are
// decoded from the next-state counter values, so every output in a given
// cycle describes the same (hcount, vcount) position.
//
// Ports
//   clk          in   1   pixel clock, rising edge
//   rst          in   1   synchronous active-high reset
//   hcount       out  11  pixel column, 0..HTOTAL-1
//   hsync        out  1   horizontal sync, active-high
//   hblnk        out  1   horizontal blanking
//   vcount       out  11  line number, 0..VTOTAL-1
//   vsync        out  1   vertical sync, active-high
//   vblnk        out  1   vertical blanking
//   line_start   out  1   one-cycle strobe on pixel 0 of each line
//   frame_start  out  1   one-cycle strobe on pixel (0,0) of each frame
//   frame_cnt    out  16  frame counter, wraps 16'hFFFF -> 0
// ---------------------------------------------------------------------------
module vga_timing #(
    parameter int HVIS   = 800,
    parameter int HFP    = 40,
    parameter int HSW    = 128,
    parameter int HTOTAL = 1056,
    parameter int VVIS   = 600,
    parameter int VFP    = 1,
    parameter int VSW    = 4,
    parameter int VTOTAL = 628
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] hcount,
    output logic        hsync,
    output logic        hblnk,
    output logic [10:0] vcount,
    output logic        vsync,
    output logic        vblnk,
    output logic        line_start,
    output logic        frame_start,
    output logic [15:0] frame_cnt
);

    // Reject timings that cannot be represented or have no back porch.
    if ((HVIS + HFP + HSW) >= HTOTAL) begin : g_bad_htiming
        $error("vga_timing: HVIS+HFP+HSW must be less than HTOTAL");
    end
    if ((VVIS + VFP + VSW) >= VTOTAL) begin : g_bad_vtiming
        $error("vga_timing: VVIS+VFP+VSW must be less than VTOTAL");
    end
    if (HTOTAL > 2048) begin : g_bad_htotal
        $error("vga_timing: HTOTAL must not exceed 2048");
    end
    if (VTOTAL > 2048) begin : g_bad_vtotal
        $error("vga_timing: VTOTAL must not exceed 2048");
    end

    localparam logic [10:0] H_LAST       = 11'(HTOTAL - 1);
    localparam logic [10:0] H_BLNK_FIRST = 11'(HVIS);
    localparam logic [10:0] H_SYNC_FIRST = 11'(HVIS + HFP);
    localparam logic [10:0] H_SYNC_LAST  = 11'(HVIS + HFP + HSW - 1);
    localparam logic [10:0] V_LAST       = 11'(VTOTAL - 1);
    localparam logic [10:0] V_BLNK_FIRST = 11'(VVIS);
    localparam logic [10:0] V_SYNC_FIRST = 11'(VVIS + VFP);
    localparam logic [10:0] V_SYNC_LAST  = 11'(VVIS + VFP + VSW - 1);

    logic        h_last;
    logic        v_last;
    logic [10:0] hcount_nxt;
    logic [10:0] vcount_nxt;
    logic        hsync_nxt;
    logic        hblnk_nxt;
    logic        vsync_nxt;
    logic        vblnk_nxt;
    logic        line_start_nxt;
    logic        frame_start_nxt;
    logic [15:0] frame_cnt_nxt;

    // Next-state counters and flag decode (flags use the *_nxt counters so
    // they land in the same cycle as the position they describe).
    always_comb begin
        h_last     = (hcount == H_LAST);
        v_last     = (vcount == V_LAST);

        hcount_nxt = h_last ? 11'd0 : hcount + 11'd1;
        vcount_nxt = vcount;
        if (h_last) begin
            vcount_nxt = v_last ? 11'd0 : vcount + 11'd1;
        end

        // The counters never exceed H_LAST / V_LAST, so blanking only needs
        // the lower bound.
        hblnk_nxt = (hcount_nxt >= H_BLNK_FIRST);
        hsync_nxt = (hcount_nxt >= H_SYNC_FIRST) && (hcount_nxt <= H_SYNC_LAST);
        vblnk_nxt = (vcount_nxt >= V_BLNK_FIRST);
        vsync_nxt = (vcount_nxt >= V_SYNC_FIRST) && (vcount_nxt <= V_SYNC_LAST);

        // Strobes come only from a wrap; the (0,0) shown during reset is not
        // a wrap and therefore carries no strobe.
        line_start_nxt  = h_last;
        frame_start_nxt = h_last && v_last;
        frame_cnt_nxt   = frame_start_nxt ? frame_cnt + 16'd1 : frame_cnt;
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= 1'b0;
            hblnk       <= 1'b0;
            vsync       <= 1'b0;
            vblnk       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            hcount      <= hcount_nxt;
            vcount      <= vcount_nxt;
            hsync       <= hsync_nxt;
            hblnk       <= hblnk_nxt;
            vsync       <= vsync_nxt;
            vblnk       <= vblnk_nxt;
            line_start  <= line_start_nxt;
            frame_start <= frame_start_nxt;
            frame_cnt   <= frame_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_timing
// Bench for vga_timing using a reduced raster (32 x 16, 512 clocks/frame).
// A position model derives every output from the number of non-reset edges
// since the last reset; directed sequences add hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_vga_timing;

    localparam int HVIS   = 16;
    localparam int HFP    = 4;
    localparam int HSW    = 6;
    localparam int HTOTAL = 32;
    localparam int VVIS   = 10;
    localparam int VFP    = 1;
    localparam int VSW    = 2;
    localparam int VTOTAL = 16;
    localparam int FRAME  = HTOTAL * VTOTAL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic        line_start;
    logic        frame_start;
    logic [15:0] frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    vga_timing #(
        .HVIS(HVIS), .HFP(HFP), .HSW(HSW), .HTOTAL(HTOTAL),
        .VVIS(VVIS), .VFP(VFP), .VSW(VSW), .VTOTAL(VTOTAL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hcount(hcount),
        .hsync(hsync),
        .hblnk(hblnk),
        .vcount(vcount),
        .vsync(vsync),
        .vblnk(vblnk),
        .line_start(line_start),
        .frame_start(frame_start),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: t = non-reset edges since the last reset edge.
    int t     = 0;
    bit ready = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            t     <= 0;
            ready <= 1'b1;
        end else if (ready) begin
            t <= t + 1;
        end
    end

    always @(negedge clk) begin : compare
        int pos;
        int eh;
        int ev;
        if (ready) begin
            pos = t % FRAME;
            eh  = pos % HTOTAL;
            ev  = pos / HTOTAL;
            chk("m_hcount", int'(hcount), eh);
            chk("m_vcount", int'(vcount), ev);
            chk("m_hblnk", int'(hblnk), int'(eh >= HVIS));
            chk("m_hsync", int'(hsync), int'(eh >= HVIS + HFP && eh < HVIS + HFP + HSW));
            chk("m_vblnk", int'(vblnk), int'(ev >= VVIS));
            chk("m_vsync", int'(vsync), int'(ev >= VVIS + VFP && ev < VVIS + VFP + VSW));
            chk("m_line_start", int'(line_start), int'(t > 0 && eh == 0));
            chk("m_frame_start", int'(frame_start), int'(t > 0 && pos == 0));
            chk("m_frame_cnt", int'(frame_cnt), (t / FRAME) % 65536);
        end
    end

    task automatic wait_pos(input int h, input int v, input string name);
        int n = 0;
        while (!(int'(hcount) == h && int'(vcount) == v) && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_reached"}, int'(int'(hcount) == h && int'(vcount) == v), 1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int rise_h;
        int hs_cnt;
        int hs_first;
        int hs_last;
        int n;
        logic prev_hblnk;
        logic [15:0] vs_mask;
        logic [15:0] vb_mask;

        // Reset held for 3 clocks, then released.
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_hcount", int'(hcount), 0);
        chk("rst_vcount", int'(vcount), 0);
        chk("rst_flags", int'({hsync, hblnk, vsync, vblnk, line_start, frame_start}), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        rst = 1'b0;
        @(negedge clk); chk("rel_h1", int'(hcount), 1); chk("rel_v0", int'(vcount), 0);
        @(negedge clk); chk("rel_h2", int'(hcount), 2);
        @(negedge clk); chk("rel_h3", int'(hcount), 3);

        // Line wrap from (31,5).
        wait_pos(31, 5, "line_end");
        chk("wrap_hblnk_before", int'(hblnk), 1);
        @(negedge clk);
        chk("wrap_hcount", int'(hcount), 0);
        chk("wrap_vcount", int'(vcount), 6);
        chk("wrap_line_start", int'(line_start), 1);
        chk("wrap_frame_start", int'(frame_start), 0);
        chk("wrap_hblnk_after", int'(hblnk), 0);

        // Sweep line 6 for the horizontal windows.
        rise_h = -1; hs_cnt = 0; hs_first = -1; hs_last = -1; prev_hblnk = hblnk;
        for (int i = 0; i < HTOTAL; i++) begin
            if (hblnk && !prev_hblnk) rise_h = int'(hcount);
            if (hsync) begin
                if (hs_first < 0) hs_first = int'(hcount);
                hs_last = int'(hcount);
                hs_cnt++;
            end
            prev_hblnk = hblnk;
            @(negedge clk);
        end
        chk("hblnk_rise_h", rise_h, 16);
        chk("hsync_first", hs_first, 20);
        chk("hsync_last", hs_last, 25);
        chk("hsync_width", hs_cnt, 6);
        chk("line_end_hsync", int'(hsync), 0);
        chk("line_end_hblnk", int'(hblnk), 0);
        chk("sweep_pos_v", int'(vcount), 7);

        // Sweep lines 7..15 for the vertical windows.
        vs_mask = '0; vb_mask = '0; n = 0;
        while (!(hcount == 11'd31 && vcount == 11'd15) && n < 2 * FRAME) begin
            if (hcount == 11'd0) begin
                vs_mask[vcount[3:0]] = vsync;
                vb_mask[vcount[3:0]] = vblnk;
            end
            @(negedge clk);
            n++;
        end
        chk("frame_end_reached", int'(hcount == 11'd31 && vcount == 11'd15), 1);
        chk("vsync_lines", int'(vs_mask), 16'h1800);
        chk("vblnk_lines", int'(vb_mask), 16'hFC00);

        // Frame wrap.
        @(negedge clk);
        chk("fwrap_hcount", int'(hcount), 0);
        chk("fwrap_vcount", int'(vcount), 0);
        chk("fwrap_frame_start", int'(frame_start), 1);
        chk("fwrap_line_start", int'(line_start), 1);
        chk("fwrap_frame_cnt", int'(frame_cnt), 1);

        // Three frame periods.
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!frame_start && n < 2 * FRAME);
            chk("frame_period", n, 512);
        end
        chk("frame_cnt_after_3", int'(frame_cnt), 4);

        // Mid-frame reset at (12,7) for one clock.
        wait_pos(12, 7, "midreset_pos");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_hcount", int'(hcount), 0);
        chk("mrst_vcount", int'(vcount), 0);
        chk("mrst_frame_cnt", int'(frame_cnt), 0);
        chk("mrst_strobes", int'({line_start, frame_start}), 0);
        @(negedge clk);
        chk("mrst_h1", int'(hcount), 1);
        chk("mrst_v0", int'(vcount), 0);
        wait_pos(31, 15, "mrst_frame_end");
        @(negedge clk);
        chk("mrst_next_frame_start", int'(frame_start), 1);
        chk("mrst_next_frame_cnt", int'(frame_cnt), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
